cam_datapath: RTL and testbench

Storage half of the 8-entry fully associative CAM. Holds per-entry key, value, valid bit and LRU age, and presents hit, valid and age vectors to `cam_controller`. Applies the one-hot write/read strobes and the LRU increment mask that `cam_controller` returns. `cam_controller` is purely combinational, so this block holds all CAM state.

---
 rtl/cam_datapath.sv | 95 +++++++++
 tb/tb_cam_datapath.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_datapath.sv
// Storage half of the 8-entry fully associative CAM.
// Holds key/value/valid/age per entry and applies controller strobes.
module cam_datapath #(
  parameter int camsize_p   = 8,
  parameter int key_width_p = 16,
  parameter int val_width_p = 16,
  parameter int lru_p       = 7
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [key_width_p-1:0]               key_i,
  input  logic [val_width_p-1:0]               val_i,
  output logic [val_width_p-1:0]               val_o,
  output logic                                 err_o,
  output logic [camsize_p-1:0]                 hits_d_c,
  output logic [camsize_p-1:0]                 valids_d_c,
  output logic [camsize_p-1:0][2:0]            lrus_d_c,
  input  logic [$clog2(camsize_p)-1:0]         read_idx_c_d,
  input  logic [camsize_p-1:0]                 write_c_d,
  input  logic [camsize_p-1:0]                 read_c_d,
  input  logic [camsize_p-1:0]                 increment_lru_c_d
);

  localparam logic [2:0] lru_c = 3'(lru_p);

  logic [key_width_p-1:0]     key_q [camsize_p];
  logic [key_width_p-1:0]     key_d [camsize_p];
  logic [val_width_p-1:0]     val_q [camsize_p];
  logic [val_width_p-1:0]     val_d [camsize_p];
  logic [camsize_p-1:0]       valid_q, valid_d;
  logic [camsize_p-1:0][2:0]  age_q, age_d;
  logic                       err_q, err_d;
  logic                       viol;

  always_comb begin
    hits_d_c = '0;
    for (int i = 0; i < camsize_p; i++) begin
      hits_d_c[i] = valid_q[i] && (key_q[i] == key_i);
    end
  end

  assign val_o      = val_q[read_idx_c_d];
  assign valids_d_c = valid_q;
  assign lrus_d_c   = age_q;
  assign err_o      = err_q;

  // Strobe beats increment; age saturates at the LRU value.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    for (int i = 0; i < camsize_p; i++) begin
      key_d[i] = key_q[i];
      val_d[i] = val_q[i];
      if (write_c_d[i]) begin
        key_d[i]   = key_i;
        val_d[i]   = val_i;
        valid_d[i] = 1'b1;
        age_d[i]   = '0;
      end else if (read_c_d[i]) begin
        age_d[i] = '0;
      end else if (increment_lru_c_d[i] && age_q[i] != lru_c) begin
        age_d[i] = age_q[i] + 3'd1;
      end
    end
  end

  always_comb begin
    viol = ((write_c_d & (write_c_d - 1'b1)) != '0)
        || ((read_c_d & (read_c_d - 1'b1)) != '0)
        || ((write_c_d != '0) && (read_c_d != '0))
        || ((hits_d_c & (hits_d_c - 1'b1)) != '0);
    err_d = err_q | viol;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < camsize_p; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
      valid_q <= '0;
      age_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < camsize_p; i++) begin
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
      valid_q <= valid_d;
      age_q   <= age_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cam_datapath.sv
// Directed self-checking bench for cam_datapath.
// Scenario tasks drive strobes and compare against hand-computed values.
module tb_cam_datapath;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [15:0]      key_i;
  logic [15:0]      val_i;
  logic [15:0]      val_o;
  logic             err_o;
  logic [7:0]       hits_d_c;
  logic [7:0]       valids_d_c;
  logic [7:0][2:0]  lrus_d_c;
  logic [2:0]       read_idx_c_d;
  logic [7:0]       write_c_d;
  logic [7:0]       read_c_d;
  logic [7:0]       increment_lru_c_d;

  int errors = 0;
  int checks = 0;

  cam_datapath dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .key_i             (key_i),
    .val_i             (val_i),
    .val_o             (val_o),
    .err_o             (err_o),
    .hits_d_c          (hits_d_c),
    .valids_d_c        (valids_d_c),
    .lrus_d_c          (lrus_d_c),
    .read_idx_c_d      (read_idx_c_d),
    .write_c_d         (write_c_d),
    .read_c_d          (read_c_d),
    .increment_lru_c_d (increment_lru_c_d)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    write_c_d = '0;
    read_c_d = '0;
    increment_lru_c_d = '0;
  endtask

  task automatic do_write(input logic [7:0] w, input logic [15:0] k,
                          input logic [15:0] v, input logic [7:0] inc);
    write_c_d = w;
    key_i = k;
    val_i = v;
    increment_lru_c_d = inc;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    key_i = '0;
    val_i = '0;
    read_idx_c_d = '0;
    idle();
    #2;
    checks++;
    if (valids_d_c !== 8'h00) begin
      errors++;
      $display("FAIL reset_valids: got %h want 00", valids_d_c);
    end
    checks++;
    if (lrus_d_c !== 24'h0) begin
      errors++;
      $display("FAIL reset_lrus: got %h want 000000", lrus_d_c);
    end
    checks++;
    if (err_o !== 1'b0 || val_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_err_val: got err=%b val=%h want 0/0000", err_o, val_o);
    end
    checks++;
    if (hits_d_c !== 8'h00) begin
      errors++;
      $display("FAIL reset_invalid_nohit: got %h want 00", hits_d_c);
    end
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    logic [7:0] vm;
    vm = '0;
    for (int i = 0; i < 8; i++) begin
      do_write(8'(1 << i), 16'h10 + 16'(i), 16'hA0 + 16'(i), vm);
      vm = vm | 8'(1 << i);
    end
    checks++;
    if (valids_d_c !== 8'hFF) begin
      errors++;
      $display("FAIL fill_valids: got %h want ff", valids_d_c);
    end
    checks++;
    if (lrus_d_c !== {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}) begin
      errors++;
      $display("FAIL fill_lrus: got %h want 053977", lrus_d_c);
    end
    key_i = 16'h15;
    read_idx_c_d = 3'd5;
    #1;
    checks++;
    if (hits_d_c !== 8'h20 || val_o !== 16'hA5) begin
      errors++;
      $display("FAIL fill_lookup: got hits=%h val=%h want 20/00a5",
               hits_d_c, val_o);
    end
  endtask

  task automatic test_replace();
    do_write(8'h01, 16'h20, 16'hB0, 8'hFF);
    checks++;
    if (lrus_d_c !== {3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd0}) begin
      errors++;
      $display("FAIL replace_lrus: got %h", lrus_d_c);
    end
    key_i = 16'h10;
    #1;
    checks++;
    if (hits_d_c !== 8'h00) begin
      errors++;
      $display("FAIL replace_old_miss: got %h want 00", hits_d_c);
    end
    key_i = 16'h20;
    read_idx_c_d = 3'd0;
    #1;
    checks++;
    if (hits_d_c !== 8'h01 || val_o !== 16'hB0) begin
      errors++;
      $display("FAIL replace_new_hit: got hits=%h val=%h want 01/00b0",
               hits_d_c, val_o);
    end
  endtask

  task automatic test_read_hit();
    key_i = 16'h14;
    #1;
    checks++;
    if (hits_d_c !== 8'h10) begin
      errors++;
      $display("FAIL read_hit_lookup: got %h want 10", hits_d_c);
    end
    read_c_d = 8'h10;
    increment_lru_c_d = 8'hE1;
    tick();
    idle();
    #1;
    checks++;
    if (lrus_d_c !== {3'd2,3'd3,3'd4,3'd0,3'd5,3'd6,3'd7,3'd1}) begin
      errors++;
      $display("FAIL read_hit_lrus: got %h", lrus_d_c);
    end
  endtask

  task automatic test_write_hit();
    key_i = 16'h13;
    read_idx_c_d = 3'd3;
    val_i = 16'hCC;
    write_c_d = 8'h08;
    increment_lru_c_d = 8'hF1;
    #1;
    checks++;
    if (hits_d_c !== 8'h08 || val_o !== 16'hA3) begin
      errors++;
      $display("FAIL write_hit_prewrite: got hits=%h val=%h want 08/00a3",
               hits_d_c, val_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (valids_d_c !== 8'hFF || hits_d_c !== 8'h08 || val_o !== 16'hCC) begin
      errors++;
      $display("FAIL write_hit_update: got v=%h hits=%h val=%h want ff/08/00cc",
               valids_d_c, hits_d_c, val_o);
    end
    checks++;
    if (lrus_d_c !== {3'd3,3'd4,3'd5,3'd1,3'd0,3'd6,3'd7,3'd2}) begin
      errors++;
      $display("FAIL write_hit_lrus: got %h", lrus_d_c);
    end
  endtask

  task automatic test_saturate_idle();
    increment_lru_c_d = 8'h02;
    repeat (3) tick();
    idle();
    #1;
    checks++;
    if (lrus_d_c !== {3'd3,3'd4,3'd5,3'd1,3'd0,3'd6,3'd7,3'd2}) begin
      errors++;
      $display("FAIL saturate_lrus: got %h", lrus_d_c);
    end
    repeat (2) tick();
    checks++;
    if (lrus_d_c !== {3'd3,3'd4,3'd5,3'd1,3'd0,3'd6,3'd7,3'd2}
        || valids_d_c !== 8'hFF || err_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got lrus=%h v=%h err=%b",
               lrus_d_c, valids_d_c, err_o);
    end
  endtask

  task automatic test_err_multi_write();
    key_i = 16'h0;
    do_write(8'h03, 16'h55, 16'h11, 8'h00);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_multi_write: got %b want 1", err_o);
    end
    key_i = 16'h0;
    repeat (2) tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0 || valids_d_c !== 8'h00 || lrus_d_c !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: got err=%b v=%h lrus=%h want 0/00/000000",
               err_o, valids_d_c, lrus_d_c);
    end
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_err_read_write();
    write_c_d = 8'h01;
    read_c_d = 8'h02;
    key_i = 16'h77;
    tick();
    idle();
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_read_write: got %b want 1", err_o);
    end
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_err_multi_hit();
    do_write(8'h01, 16'h33, 16'h01, 8'h00);
    do_write(8'h02, 16'h33, 16'h02, 8'h01);
    checks++;
    if (hits_d_c !== 8'h03 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL multi_hit_pre: got hits=%h err=%b want 03/0",
               hits_d_c, err_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_multi_hit: got %b want 1", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_replace();
    test_read_hit();
    test_write_hit();
    test_saturate_idle();
    test_err_multi_write();
    test_async_reset();
    test_err_read_write();
    test_err_multi_hit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
